// File: rtl/core_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// core_mem_bridge_pkg
//   Shared types and constants for the core-to-memory bridge: the FSM state
//   encoding and the width of the packed {wstrb, addr, wdata} request bus.
//   Imported by core_mem_bridge.
// -----------------------------------------------------------------------------
package core_mem_bridge_pkg;

  localparam int MEM_BRIDGE_STATE_WD = 3;

  typedef enum logic [MEM_BRIDGE_STATE_WD-1:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_WAIT = 3'd4,
    ST_DONE   = 3'd5
  } bridge_state_e;

  // Width of the packed {wstrb, addr, wdata} request bus for a given
  // address and data width (one strobe bit per data byte).
  function automatic int mem_req_width(input int addr_w, input int data_w);
    return (data_w / 8) + addr_w + data_w;
  endfunction

  localparam int MEM_REQ_WD = mem_req_width(32, 32);

endpackage

// File: rtl/mem_bridge_perf.sv
// -----------------------------------------------------------------------------
// mem_bridge_perf
//   Performance counter bank for core_mem_bridge. Only instantiated when
//   CORE_MEM_BRIDGE_PERF_EN is defined. All counters wrap at 2^CNT_WIDTH.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   i_stall           stallreq_for_mem of the bridge
//   i_inst_gnt        instruction request accepted this cycle
//   i_data_gnt        data request accepted this cycle
//   o_stall_cycles    cycles with the stall request high
//   o_inst_reqs       granted instruction requests
//   o_data_reqs       granted data requests
// -----------------------------------------------------------------------------
module mem_bridge_perf #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stall,
  input  logic                 i_inst_gnt,
  input  logic                 i_data_gnt,
  output logic [CNT_WIDTH-1:0] o_stall_cycles,
  output logic [CNT_WIDTH-1:0] o_inst_reqs,
  output logic [CNT_WIDTH-1:0] o_data_reqs
);

  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_inst_reqs;
  logic [CNT_WIDTH-1:0] r_data_reqs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_inst_reqs    <= '0;
      r_data_reqs    <= '0;
    end else begin
      if (i_stall)    r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      if (i_inst_gnt) r_inst_reqs    <= r_inst_reqs + CNT_WIDTH'(1);
      if (i_data_gnt) r_data_reqs    <= r_data_reqs + CNT_WIDTH'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_inst_reqs    = r_inst_reqs;
  assign o_data_reqs    = r_data_reqs;

endmodule

// File: rtl/core_mem_bridge.sv
// -----------------------------------------------------------------------------
// core_mem_bridge
//   Serialises the core's instruction and data SRAM-style ports onto a single
//   variable-latency req/gnt/rvalid memory bus. Data goes first (it belongs to
//   the older instruction), then instruction. While either access is pending
//   stallreq_for_mem is high; it drops for exactly one cycle (DONE) so the
//   pipeline advances, and the registered rdata is consumed the cycle after.
//
// Optional feature: define CORE_MEM_BRIDGE_PERF_EN to add the perf_* counter
//   outputs (stall cycles, granted instruction and data requests).
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   inst_sram_en/wen/addr/wdata  fetch request (wen, wdata ignored)
//   inst_sram_rdata              registered fetch data
//   data_sram_en/wen/addr/wdata  load/store request (wen==0 means load)
//   data_sram_rdata              registered load data
//   stallreq_for_mem             stall request to CTRL (combinational)
//   mem_req/wstrb/addr/wdata     bus request, held until mem_gnt
//   mem_gnt                      slave accepted the request this cycle
//   mem_rvalid/mem_rdata         one response per granted request
//   perf_*                       counters (CORE_MEM_BRIDGE_PERF_EN only)
// -----------------------------------------------------------------------------
module core_mem_bridge
  import core_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_sram_en,
  input  logic [DATA_WIDTH/8-1:0] inst_sram_wen,
  input  logic [ADDR_WIDTH-1:0]   inst_sram_addr,
  input  logic [DATA_WIDTH-1:0]   inst_sram_wdata,
  output logic [DATA_WIDTH-1:0]   inst_sram_rdata,
  input  logic                    data_sram_en,
  input  logic [DATA_WIDTH/8-1:0] data_sram_wen,
  input  logic [ADDR_WIDTH-1:0]   data_sram_addr,
  input  logic [DATA_WIDTH-1:0]   data_sram_wdata,
  output logic [DATA_WIDTH-1:0]   data_sram_rdata,
  output logic                    stallreq_for_mem,
  output logic                    mem_req,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef CORE_MEM_BRIDGE_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] perf_inst_reqs,
  output logic [PERF_CNT_WIDTH-1:0] perf_data_reqs
`endif
);

  localparam int REQ_WD = mem_req_width(ADDR_WIDTH, DATA_WIDTH);

  bridge_state_e         r_state;
  bridge_state_e         w_next_state;
  logic [REQ_WD-1:0]     w_req_bus;
  logic                  w_d_capture;
  logic                  w_i_capture;
  logic [DATA_WIDTH-1:0] r_inst_rdata;
  logic [DATA_WIDTH-1:0] r_data_rdata;
  logic                  r_d_done;
  logic                  r_i_done;

  // Fetches are always reads, so the instruction-side write inputs are dead.
  logic w_unused_inst_wr;
  assign w_unused_inst_wr = ^{inst_sram_wen, inst_sram_wdata};

  // ---------------------------------------------------------------------------
  // Next state and bus drive. Core inputs are forwarded live: the core holds
  // them stable while stalled, so nothing is latched here.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    w_next_state = r_state;
    mem_req      = 1'b0;
    w_req_bus    = '0;
    w_d_capture  = 1'b0;
    w_i_capture  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (data_sram_en)      w_next_state = ST_D_REQ;
        else if (inst_sram_en) w_next_state = ST_I_REQ;
      end
      ST_D_REQ: begin
        mem_req   = 1'b1;
        w_req_bus = {data_sram_wen, data_sram_addr, data_sram_wdata};
        if (mem_gnt) w_next_state = ST_D_WAIT;
      end
      ST_D_WAIT: begin
        if (mem_rvalid) begin
          w_d_capture  = 1'b1;
          w_next_state = inst_sram_en ? ST_I_REQ : ST_DONE;
        end
      end
      ST_I_REQ: begin
        mem_req   = 1'b1;
        w_req_bus = {{(DATA_WIDTH/8){1'b0}}, inst_sram_addr, {DATA_WIDTH{1'b0}}};
        if (mem_gnt) w_next_state = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        if (mem_rvalid) begin
          w_i_capture  = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign {mem_wstrb, mem_addr, mem_wdata} = w_req_bus;

  // High from the first cycle a request appears, low only in DONE so the
  // pipeline advances at exactly that edge.
  assign stallreq_for_mem = (r_state != ST_DONE) && (inst_sram_en || data_sram_en);

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= ST_IDLE;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // A store's rvalid is only a write ack; keep the last load data.
      if (w_d_capture && (data_sram_wen == '0)) r_data_rdata <= mem_rdata;
      if (w_i_capture)                          r_inst_rdata <= mem_rdata;
      if (r_state == ST_DONE) begin
        r_d_done <= 1'b0;
        r_i_done <= 1'b0;
      end else begin
        if (w_d_capture) r_d_done <= 1'b1;
        if (w_i_capture) r_i_done <= 1'b1;
      end
    end
  end

  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;

  // DONE is only reachable through a response capture.
  a_done_after_capture: assert property (
    @(posedge clk) disable iff (rst)
    (r_state == ST_DONE) |-> (r_d_done || r_i_done)
  );

`ifdef CORE_MEM_BRIDGE_PERF_EN
  mem_bridge_perf #(
    .CNT_WIDTH (PERF_CNT_WIDTH)
  ) u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (stallreq_for_mem),
    .i_inst_gnt     (mem_gnt && (r_state == ST_I_REQ)),
    .i_data_gnt     (mem_gnt && (r_state == ST_D_REQ)),
    .o_stall_cycles (perf_stall_cycles),
    .o_inst_reqs    (perf_inst_reqs),
    .o_data_reqs    (perf_data_reqs)
  );
`else
  logic [31:0] w_unused_perf_width;
  assign w_unused_perf_width = 32'(PERF_CNT_WIDTH);
`endif

endmodule

// File: tb/tb_core_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_core_mem_bridge
//   Self-checking bench for core_mem_bridge. A core driver presents whole
//   transactions, a slave model answers with per-access gnt/rvalid delays, and
//   a transaction-level reference (queue of expected bus accesses plus the
//   rdata values the core must see) is compared every cycle.
// -----------------------------------------------------------------------------
module tb_core_mem_bridge;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;
  logic        mem_req;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef CORE_MEM_BRIDGE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_inst_reqs;
  logic [31:0] perf_data_reqs;
`endif

  core_mem_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_wen    (inst_sram_wen),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .stallreq_for_mem (stallreq_for_mem),
    .mem_req          (mem_req),
    .mem_wstrb        (mem_wstrb),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata)
`ifdef CORE_MEM_BRIDGE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_inst_reqs    (perf_inst_reqs),
    .perf_data_reqs    (perf_data_reqs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access as the reference expects it, plus the slave's timing.
  typedef struct {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          is_inst;
    int          g;  // req cycles before gnt (0 = gnt on first req cycle)
    int          r;  // cycles from gnt to rvalid (>= 1)
  } acc_t;

  typedef struct {
    bit          d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    int          dg;
    int          dr;
    bit          i_en;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    int          ig;
    int          ir;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  acc_t        exp_q[$];
  acc_t        pend;
  bit          pend_valid   = 1'b0;
  int          since        = 0;
  int          req_wait     = 0;
  bit          model_done   = 1'b0;
  logic [31:0] exp_inst_rdata = '0;
  logic [31:0] exp_data_rdata = '0;
  int          m_inst_gnts  = 0;
  int          m_data_gnts  = 0;
  int          m_stall_cycles = 0;

  bit new_txn   = 1'b0;
  bit stray_req = 1'b0;
  bit mon_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit d_en, input logic [3:0] d_wen,
                              input logic [31:0] d_addr, input logic [31:0] d_wdata,
                              input logic [31:0] d_rdata, input int dg, input int dr,
                              input bit i_en, input logic [31:0] i_addr,
                              input logic [31:0] i_rdata, input int ig, input int ir);
    txn_t t;
    t.d_en = d_en; t.d_wen = d_wen; t.d_addr = d_addr; t.d_wdata = d_wdata;
    t.d_rdata = d_rdata; t.dg = dg; t.dr = dr;
    t.i_en = i_en; t.i_addr = i_addr; t.i_rdata = i_rdata; t.ig = ig; t.ir = ir;
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Slave model: commits what happened at the last edge, then drives this
  // cycle's gnt/rvalid.
  // ---------------------------------------------------------------------------
  initial begin
    bit          l_gnt, l_req, l_rv, l_rst;
    l_gnt = 0; l_req = 0; l_rv = 0; l_rst = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk); #2;
      model_done = 1'b0;
      if (l_rst) begin
        exp_q.delete();
        pend_valid     = 1'b0;
        req_wait       = 0;
        exp_inst_rdata = '0;
        exp_data_rdata = '0;
        m_inst_gnts    = 0;
        m_data_gnts    = 0;
        m_stall_cycles = 0;
      end else begin
        if (l_rv && pend_valid) begin
          if (pend.is_inst)           exp_inst_rdata = pend.rdata;
          else if (pend.wstrb == 4'h0) exp_data_rdata = pend.rdata;
          pend_valid = 1'b0;
          model_done = (exp_q.size() == 0);
        end
        if (l_gnt && l_req && exp_q.size() > 0) begin
          pend       = exp_q.pop_front();
          pend_valid = 1'b1;
          since      = 1;
          req_wait   = 0;
          if (pend.is_inst) m_inst_gnts++;
          else              m_data_gnts++;
        end else if (l_req) begin
          req_wait++;
        end
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!rst) begin
        if (mem_req && exp_q.size() > 0 && !pend_valid && req_wait == exp_q[0].g)
          mem_gnt = 1'b1;
        if (pend_valid) begin
          if (since == pend.r) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend.rdata;
          end else begin
            since++;
          end
        end else if (stray_req) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEADBEEF;
        end
      end
      stray_req = 1'b0;
      l_gnt = mem_gnt; l_req = mem_req; l_rv = mem_rvalid; l_rst = rst;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every cycle after the initial reset.
  // ---------------------------------------------------------------------------
  initial begin
    bit exp_stall, exp_req;
    forever begin
      @(negedge clk); #4;
      if (mon_en) begin
        exp_stall = (inst_sram_en || data_sram_en) && !model_done;
        exp_req   = (exp_q.size() > 0) && !pend_valid && !new_txn;
        check("mon_stall", 64'(stallreq_for_mem), 64'(exp_stall));
        check("mon_req", 64'(mem_req), 64'(exp_req));
        if (mem_req && exp_q.size() > 0) begin
          check("mon_wstrb", 64'(mem_wstrb), 64'(exp_q[0].wstrb));
          check("mon_addr", 64'(mem_addr), 64'(exp_q[0].addr));
          if (exp_q[0].wstrb != 4'h0)
            check("mon_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
        end
        check("mon_inst_rdata", 64'(inst_sram_rdata), 64'(exp_inst_rdata));
        check("mon_data_rdata", 64'(data_sram_rdata), 64'(exp_data_rdata));
        if (exp_stall) m_stall_cycles++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Core driver
  // ---------------------------------------------------------------------------
  task automatic present(input txn_t t);
    @(negedge clk);
    data_sram_en    = t.d_en;
    data_sram_wen   = t.d_en ? t.d_wen : 4'h0;
    data_sram_addr  = t.d_addr;
    data_sram_wdata = t.d_wdata;
    inst_sram_en    = t.i_en;
    inst_sram_addr  = t.i_addr;
    inst_sram_wen   = 4'($urandom);
    inst_sram_wdata = $urandom;
    if (t.d_en)
      exp_q.push_back('{wstrb: t.d_wen, addr: t.d_addr, wdata: t.d_wdata,
                        rdata: t.d_rdata, is_inst: 1'b0, g: t.dg, r: t.dr});
    if (t.i_en)
      exp_q.push_back('{wstrb: 4'h0, addr: t.i_addr, wdata: 32'h0,
                        rdata: t.i_rdata, is_inst: 1'b1, g: t.ig, r: t.ir});
    new_txn = 1'b1;
  endtask

  task automatic run_txn(input txn_t t, output int stalls);
    int exp_stalls;
    int budget;
    present(t);
    exp_stalls = 1 + (t.d_en ? t.dg + 1 + t.dr : 0) + (t.i_en ? t.ig + 1 + t.ir : 0);
    stalls = 0;
    budget = 0;
    forever begin
      #3;
      if (!stallreq_for_mem) break;
      stalls++;
      budget++;
      if (budget > 200) begin
        check("txn_timeout", 64'(budget), 64'(exp_stalls));
        break;
      end
      @(negedge clk);
      new_txn = 1'b0;
    end
    check("txn_stall_cycles", 64'(stalls), 64'(exp_stalls));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      new_txn      = 1'b0;
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st;
    txn_t t;
    rst = 1'b1;
    inst_sram_en = 0; inst_sram_wen = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    #3;
    check("rst_stall", 64'(stallreq_for_mem), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_bus", {mem_wstrb, mem_addr, mem_wdata[27:0]}, 64'd0);
    check("rst_inst_rdata", 64'(inst_sram_rdata), 64'd0);
    check("rst_data_rdata", 64'(data_sram_rdata), 64'd0);
    idle(2);

    // 1: fetch only, gnt immediately, rvalid one cycle later
    run_txn(mk(0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hBFC00000, 32'h3C08BFAF, 0, 1), st);
    check("t1_stall_cycles", 64'(st), 64'd3);
    idle(1); #3;
    check("t1_inst_rdata", 64'(inst_sram_rdata), 64'h3C08BFAF);

    // 2: load plus fetch, data goes first on the bus
    run_txn(mk(1, 4'h0, 32'h80001000, 32'h12345678, 32'h11223344, 0, 1,
               1, 32'hBFC00004, 32'h55667788, 1, 2), st);
    check("t2_stall_cycles", 64'(st), 64'd7);
    idle(2); #3;
    check("t2_data_rdata", 64'(data_sram_rdata), 64'h11223344);
    check("t2_inst_rdata", 64'(inst_sram_rdata), 64'h55667788);

    // 3: store; the write ack carries junk that must not reach the core
    run_txn(mk(1, 4'b0011, 32'h80001004, 32'h0000ABCD, 32'hFFFF0000, 0, 1,
               0, 0, 0, 0, 0), st);
    idle(1); #3;
    check("t3_data_rdata_kept", 64'(data_sram_rdata), 64'h11223344);

    // 4: slow slave, gnt after 4 cycles, rvalid 3 cycles after that
    run_txn(mk(1, 4'h0, 32'h80002000, 32'h0, 32'hCAFE0001, 4, 3,
               1, 32'hBFC00008, 32'hCAFE0002, 4, 3), st);
    check("t4_stall_cycles", 64'(st), 64'd17);
    idle(1);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 4);
      t = mk(kind != 0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
             $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(1, 4),
             kind != 1, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(1, 4));
      run_txn(t, st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1); #3;
`ifdef CORE_MEM_BRIDGE_PERF_EN
    check("perf_inst_reqs_rand", 64'(perf_inst_reqs), 64'(m_inst_gnts));
    check("perf_data_reqs_rand", 64'(perf_data_reqs), 64'(m_data_gnts));
    check("perf_stall_rand", 64'(perf_stall_cycles), 64'(m_stall_cycles));
`endif

    // 5: reset during D_WAIT, then a stray rvalid
    present(mk(1, 4'h0, 32'h80003000, 32'h0, 32'h0BADF00D, 0, 4, 0, 0, 0, 0, 0));
    @(negedge clk); new_txn = 1'b0;   // D_REQ, granted
    @(negedge clk);                   // D_WAIT
    rst = 1'b1; data_sram_en = 1'b0; inst_sram_en = 1'b0;
    @(negedge clk);
    rst = 1'b0; stray_req = 1'b1;
    #3;
    check("t5_mem_req", 64'(mem_req), 64'd0);
    check("t5_stall", 64'(stallreq_for_mem), 64'd0);
    check("t5_data_rdata", 64'(data_sram_rdata), 64'd0);
    check("t5_inst_rdata", 64'(inst_sram_rdata), 64'd0);
    idle(1); #3;
    check("t5_stray_data_rdata", 64'(data_sram_rdata), 64'd0);
    check("t5_stray_inst_rdata", 64'(inst_sram_rdata), 64'd0);

    // 6: ten back-to-back fetches at minimum latency
    for (int k = 0; k < 10; k++)
      run_txn(mk(0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hBFC00100 + 32'(4 * k), $urandom, 0, 1), st);
    idle(2); #3;
    check("t6_inst_rdata_model", 64'(inst_sram_rdata), 64'(exp_inst_rdata));
`ifdef CORE_MEM_BRIDGE_PERF_EN
    check("t6_perf_inst_reqs", 64'(perf_inst_reqs), 64'd10);
    check("t6_perf_data_reqs", 64'(perf_data_reqs), 64'd0);
    check("t6_perf_stall_cycles", 64'(perf_stall_cycles), 64'd30);
    check("t6_perf_stall_model", 64'(perf_stall_cycles), 64'(m_stall_cycles));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
